// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory fetch path: widths, reset PC
// and the controller state encodings used by decode and memory as well.
package imem_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF   = 10;
    localparam int unsigned INSTR_W_DEF  = 16;
    localparam int unsigned RESET_PC_DEF = 0;

    // Encodings are fixed so other blocks can decode the controller state.
    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic fetch_advance(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage

// File: rtl/imem_fetch_stage.sv
// Output holding register toward decode: captures a fetched word on load,
// drops it on flush, and drains it once decode accepts it.
module imem_fetch_stage
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic               ready,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [ADDR_W-1:0]  d_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: boot-time program load via the write port,
// then PC-driven fetch to decode with redirect and halt/restart handling.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned INSTR_W  = INSTR_W_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_we,
    output logic [INSTR_W-1:0] imem_wdata,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               running
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              fetch_en;
    logic              flush;

    // Redirect outranks a normal advance; halt still lets this cycle's advance land.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        fetch_en  = 1'b0;
        flush     = 1'b0;
        case (state)
            ST_LOAD: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = RST_PC;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush  = 1'b1;
                    pc_nxt = redirect_pc;
                end else if (fetch_advance(if_valid, if_ready)) begin
                    fetch_en = 1'b1;
                    pc_nxt   = pc + ADDR_W'(1);
                end
                if (halt_req) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = RST_PC;
                    flush     = 1'b1;
                end else if (redirect_valid) begin
                    flush  = 1'b1;
                    pc_nxt = redirect_pc;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
            pc    <= RST_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Gated with rst_n so the loader sees no acceptance while reset is held.
    assign load_ready = rst_n && (state == ST_LOAD);
    assign imem_we    = load_ready && load_valid;
    assign imem_wdata = load_data;
    assign imem_addr  = (state == ST_LOAD) ? load_addr : pc;
    assign running    = (state == ST_RUN);

    imem_fetch_stage #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (fetch_en),
        .flush   (flush),
        .ready   (if_ready),
        .d_instr (imem_rdata),
        .d_pc    (pc),
        .valid   (if_valid),
        .instr   (if_instr),
        .pc      (if_pc)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 1024x16 memory
// (combinational read, clocked write). Unloaded words hold 0xC000|addr.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid, load_ready;
    logic [9:0]  load_addr;
    logic [15:0] load_data;
    logic        start, halt_req, redirect_valid;
    logic [9:0]  redirect_pc;
    logic [9:0]  imem_addr;
    logic        imem_we;
    logic [15:0] imem_wdata, imem_rdata;
    logic        if_valid, if_ready;
    logic [15:0] if_instr;
    logic [9:0]  if_pc;
    logic        running;

    logic [15:0] mem [1024];
    logic        mem_init;
    int          we_cnt;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .ADDR_W   (10),
        .INSTR_W  (16),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_we        (imem_we),
        .imem_wdata     (imem_wdata),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .running        (running)
    );

    assign imem_rdata = mem[imem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int unsigned i = 0; i < 1024; i++) mem[i] <= 16'hC000 | 16'(i);
        end else if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) we_cnt <= 0;
        else if (imem_we) we_cnt <= we_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (load_ready !== 1'b0) $display("FAIL rst_load_ready got %b want 0", load_ready); else passed++;
        total++; if (imem_we !== 1'b0) $display("FAIL rst_imem_we got %b want 0", imem_we); else passed++;
        total++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid got %b want 0", if_valid); else passed++;
        total++; if (running !== 1'b0) $display("FAIL rst_running got %b want 0", running); else passed++;
        total++; if (if_instr !== 16'h0) $display("FAIL rst_if_instr got %h want 0000", if_instr); else passed++;
        total++; if (if_pc !== 10'd0) $display("FAIL rst_if_pc got %0d want 0", if_pc); else passed++;
        step();
        mem_init   = 1'b0;
        load_valid = 1'b0;
        rst_n      = 1'b1;
        #1;
        total++; if (load_ready !== 1'b1) $display("FAIL rel_load_ready got %b want 1", load_ready); else passed++;
    endtask

    task automatic load_word(input logic [9:0] a, input logic [15:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        #1;
        total++; if (imem_we !== 1'b1) $display("FAIL load_we@%0d got %b want 1", a, imem_we); else passed++;
        total++; if (imem_addr !== a) $display("FAIL load_addr got %0d want %0d", imem_addr, a); else passed++;
        step();
    endtask

    task automatic test_load();
        load_word(10'd0, 16'h1603);
        load_word(10'd1, 16'h8180);
        load_word(10'd1023, 16'hFFFF);
        load_valid = 1'b0;
        // Redirect while loading must be ignored.
        redirect_valid = 1'b1;
        redirect_pc    = 10'd6;
        step();
        redirect_valid = 1'b0;
        total++; if (if_valid !== 1'b0) $display("FAIL load_redir_valid got %b want 0", if_valid); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL load_redir_ready got %b want 1", load_ready); else passed++;
        total++; if (we_cnt !== 3) $display("FAIL load_we_count got %0d want 3", we_cnt); else passed++;
        total++; if (mem[0] !== 16'h1603) $display("FAIL mem0 got %h want 1603", mem[0]); else passed++;
        total++; if (mem[1] !== 16'h8180) $display("FAIL mem1 got %h want 8180", mem[1]); else passed++;
        total++; if (mem[1023] !== 16'hFFFF) $display("FAIL mem1023 got %h want ffff", mem[1023]); else passed++;
    endtask

    task automatic test_fetch();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (running !== 1'b1) $display("FAIL start_running got %b want 1", running); else passed++;
        total++; if (if_valid !== 1'b0) $display("FAIL start_valid got %b want 0", if_valid); else passed++;
        total++; if (load_ready !== 1'b0) $display("FAIL run_load_ready got %b want 0", load_ready); else passed++;
        step();
        total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 10'd0, 16'h1603}) $display("FAIL fetch0 got v%b pc%0d %h want v1 pc0 1603", if_valid, if_pc, if_instr); else passed++;
        step();
        total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 10'd1, 16'h8180}) $display("FAIL fetch1 got v%b pc%0d %h want v1 pc1 8180", if_valid, if_pc, if_instr); else passed++;
        step();
        total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 10'd2, 16'hC002}) $display("FAIL fetch2 got v%b pc%0d %h want v1 pc2 c002", if_valid, if_pc, if_instr); else passed++;
    endtask

    task automatic test_backpressure();
        if_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 10'd2, 16'hC002}) $display("FAIL hold%0d got v%b pc%0d %h want v1 pc2 c002", k, if_valid, if_pc, if_instr); else passed++;
        end
        if_ready = 1'b1;
        step();
        total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 10'd3, 16'hC003}) $display("FAIL bp_release got v%b pc%0d %h want v1 pc3 c003", if_valid, if_pc, if_instr); else passed++;
        step();
        total++; if (if_pc !== 10'd4) $display("FAIL bp_next got pc%0d want pc4", if_pc); else passed++;
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc    = 10'd2;
        step();
        redirect_valid = 1'b0;
        total++; if (if_valid !== 1'b0) $display("FAIL redir_bubble got %b want 0", if_valid); else passed++;
        step();
        total++; if ({if_valid, if_pc} !== {1'b1, 10'd2}) $display("FAIL redir_first got v%b pc%0d want v1 pc2", if_valid, if_pc); else passed++;
        if_ready = 1'b0;
        step();
        total++; if (if_pc !== 10'd2) $display("FAIL redir_hold got pc%0d want pc2", if_pc); else passed++;
        redirect_valid = 1'b1;
        redirect_pc    = 10'd6;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        total++; if (if_valid !== 1'b0) $display("FAIL redir_discard got %b want 0", if_valid); else passed++;
        step();
        total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 10'd6, 16'hC006}) $display("FAIL redir_target got v%b pc%0d %h want v1 pc6 c006", if_valid, if_pc, if_instr); else passed++;
        step();
        total++; if (if_pc !== 10'd7) $display("FAIL redir_seq got pc%0d want pc7", if_pc); else passed++;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 10'd1022;
        step();
        redirect_valid = 1'b0;
        step();
        total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 10'd1022, 16'hC3FE}) $display("FAIL wrap1022 got v%b pc%0d %h want v1 pc1022 c3fe", if_valid, if_pc, if_instr); else passed++;
        step();
        total++; if ({if_pc, if_instr} !== {10'd1023, 16'hFFFF}) $display("FAIL wrap1023 got pc%0d %h want pc1023 ffff", if_pc, if_instr); else passed++;
        step();
        total++; if ({if_pc, if_instr} !== {10'd0, 16'h1603}) $display("FAIL wrap0 got pc%0d %h want pc0 1603", if_pc, if_instr); else passed++;
        step();
        total++; if ({if_pc, if_instr} !== {10'd1, 16'h8180}) $display("FAIL wrap1 got pc%0d %h want pc1 8180", if_pc, if_instr); else passed++;
    endtask

    task automatic test_halt_restart();
        redirect_valid = 1'b1;
        redirect_pc    = 10'd3;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        total++; if (if_pc !== 10'd4) $display("FAIL halt_setup got pc%0d want pc4", if_pc); else passed++;
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        total++; if (running !== 1'b0) $display("FAIL halt_running got %b want 0", running); else passed++;
        total++; if ({if_valid, if_pc} !== {1'b1, 10'd5}) $display("FAIL halt_last got v%b pc%0d want v1 pc5", if_valid, if_pc); else passed++;
        step();
        total++; if (if_valid !== 1'b0) $display("FAIL halt_drain got %b want 0", if_valid); else passed++;
        step();
        total++; if (if_valid !== 1'b0) $display("FAIL halt_quiet got %b want 0", if_valid); else passed++;
        load_valid = 1'b1;
        load_addr  = 10'd7;
        load_data  = 16'hBEEF;
        #1;
        total++; if (load_ready !== 1'b0) $display("FAIL halt_load_ready got %b want 0", load_ready); else passed++;
        total++; if (imem_we !== 1'b0) $display("FAIL halt_we got %b want 0", imem_we); else passed++;
        total++; if (imem_addr !== 10'd6) $display("FAIL halt_addr got %0d want 6", imem_addr); else passed++;
        step();
        load_valid = 1'b0;
        total++; if (mem[7] !== 16'hC007) $display("FAIL halt_mem7 got %h want c007", mem[7]); else passed++;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if ({running, if_valid} !== 2'b10) $display("FAIL restart got run%b v%b want run1 v0", running, if_valid); else passed++;
        step();
        total++; if ({if_valid, if_pc, if_instr} !== {1'b1, 10'd0, 16'h1603}) $display("FAIL restart_first got v%b pc%0d %h want v1 pc0 1603", if_valid, if_pc, if_instr); else passed++;
    endtask

    task automatic test_reset_midrun();
        step();
        total++; if ({if_valid, if_pc} !== {1'b1, 10'd1}) $display("FAIL midrun_pre got v%b pc%0d want v1 pc1", if_valid, if_pc); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if ({if_valid, running, load_ready} !== 3'b000) $display("FAIL midrun_async got v%b run%b lr%b want 000", if_valid, running, load_ready); else passed++;
        #1;
        rst_n = 1'b1;
        step();
        total++; if ({load_ready, running, if_valid} !== 3'b100) $display("FAIL midrun_after got lr%b run%b v%b want 100", load_ready, running, if_valid); else passed++;
        total++; if (imem_addr !== 10'd7) $display("FAIL midrun_addr got %0d want 7", imem_addr); else passed++;
    endtask

    initial begin
        rst_n          = 1'b0;
        mem_init       = 1'b1;
        load_valid     = 1'b1;
        load_addr      = '0;
        load_data      = '0;
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        test_reset();
        test_load();
        test_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt_restart();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
